// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C bus arbiter: FSM state encoding,
// address/data widths and the default start-timeout limit.
package i2c_pkg;

  localparam int CHIP_W   = 7;
  localparam int REG_W    = 8;
  localparam int DATA_W   = 8;
  localparam int STATUS_W = 3;
  localparam int TMO_W    = 10;

  localparam int DEF_START_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: scans requesters starting one past the
// pointer (mod NREQ) and returns a one-hot winner plus a valid flag.
module rr_select #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value held and infer a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Arbitrates NREQ requesters onto one i2c_master: round-robin grant, one-cycle
// command strobe, start timeout, and a done/err/read-data handback.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [CHIP_W*NREQ-1:0]   req_chip_addr,
  input  logic [REG_W*NREQ-1:0]    req_reg_addr,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          req_done,
  output logic                     req_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CHIP_W-1:0]        m_chip_addr,
  output logic [REG_W-1:0]         m_reg_addr,
  output logic [DATA_W-1:0]        m_data_in,
  output logic                     m_write_en,
  output logic                     m_read_en,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic [STATUS_W-1:0]      m_status,
  input  logic [DATA_W-1:0]        m_data_out
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(START_TIMEOUT);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CHIP_W-1:0]   chip_q, chip_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NREQ-1:0]     sel_oh;
  logic                sel_valid;
  logic [PTR_W-1:0]    sel_idx;

  rr_select #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req    (req),
    .ptr    (ptr_q),
    .winner (sel_oh),
    .valid  (sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) sel_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          gnt_d   = sel_oh;
          win_d   = sel_idx;
          chip_d  = req_chip_addr[CHIP_W*int'(sel_idx) +: CHIP_W];
          reg_d   = req_reg_addr[REG_W*int'(sel_idx) +: REG_W];
          wdata_d = req_data[DATA_W*int'(sel_idx) +: DATA_W];
          rd_d    = req_rd[sel_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (m_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          // Comparing the incremented value makes the abort land exactly
          // START_TIMEOUT+1 cycles after the strobe.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
          if (cnt_d >= TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (m_done || !m_busy) begin
          rdata_d = m_data_out;
          err_d   = (m_status != '0);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        ptr_d   = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
      chip_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      chip_q  <= chip_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes and done/err are decoded from registered state only.
  assign gnt         = gnt_q;
  assign req_done    = (state_q == ST_RELEASE) ? gnt_q : '0;
  assign req_err     = (state_q == ST_RELEASE) && err_q;
  assign rd_data     = rdata_q;
  assign m_chip_addr = chip_q;
  assign m_reg_addr  = reg_q;
  assign m_data_in   = wdata_q;
  assign m_write_en  = (state_q == ST_ISSUE) && !rd_q;
  assign m_read_en   = (state_q == ST_ISSUE) && rd_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized
// traffic, checked against a round-robin reference model and a master stand-in.
module tb_i2c_bus_arbiter;

  localparam int NREQ = 3;
  localparam int TMO  = 1023;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_rd;
  logic [7*NREQ-1:0]   req_chip_addr;
  logic [8*NREQ-1:0]   req_reg_addr;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     req_done;
  logic                req_err;
  logic [7:0]          rd_data;
  logic [6:0]          m_chip_addr;
  logic [7:0]          m_reg_addr;
  logic [7:0]          m_data_in;
  logic                m_write_en;
  logic                m_read_en;
  logic                m_busy;
  logic                m_done;
  logic [2:0]          m_status;
  logic [7:0]          m_data_out;

  logic [6:0] ca [NREQ];
  logic [7:0] ra [NREQ];
  logic [7:0] wd [NREQ];

  int checks = 0;
  int errors = 0;
  int last   = NREQ - 1;   // model: index of the last requester served

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_chip_addr[7*g +: 7] = ca[g];
    assign req_reg_addr[8*g +: 8]  = ra[g];
    assign req_data[8*g +: 8]      = wd[g];
  end

  i2c_bus_arbiter #(
    .NREQ          (NREQ),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_rd        (req_rd),
    .req_chip_addr (req_chip_addr),
    .req_reg_addr  (req_reg_addr),
    .req_data      (req_data),
    .gnt           (gnt),
    .req_done      (req_done),
    .req_err       (req_err),
    .rd_data       (rd_data),
    .m_chip_addr   (m_chip_addr),
    .m_reg_addr    (m_reg_addr),
    .m_data_in     (m_data_in),
    .m_write_en    (m_write_en),
    .m_read_en     (m_read_en),
    .m_busy        (m_busy),
    .m_done        (m_done),
    .m_status      (m_status),
    .m_data_out    (m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first set request scanning upward from last+1.
  function automatic int pick(input logic [NREQ-1:0] r, input int prev);
    for (int off = 1; off <= NREQ; off++) begin
      if (r[(prev + off) % NREQ]) return (prev + off) % NREQ;
    end
    return 0;
  endfunction

  task automatic set_cmd(input int i, input bit rd, input logic [6:0] c,
                         input logic [7:0] r, input logic [7:0] d);
    req_rd[i] = rd;
    ca[i]     = c;
    ra[i]     = r;
    wd[i]     = d;
  endtask

  // Serves one transaction as the master would, checking the arbiter side.
  task automatic serve(input int dly, input int blen, input logic [2:0] st,
                       input logic [7:0] dout, input bit via_done, input bit tmo,
                       input bit drop, input logic [NREQ-1:0] next_req,
                       output int lat);
    int w;
    int n;
    logic [NREQ-1:0] oh;
    w = pick(req, last);
    oh = '0;
    oh[w] = 1'b1;
    lat = 0;
    while (!(m_write_en || m_read_en) && lat < 8) begin
      tick();
      lat++;
    end
    check("strobe_seen", 32'(m_write_en | m_read_en), 1);
    check("gnt_at_strobe", 32'(gnt), 32'(oh));
    check("cmd_chip", 32'(m_chip_addr), 32'(ca[w]));
    check("cmd_reg", 32'(m_reg_addr), 32'(ra[w]));
    check("cmd_data", 32'(m_data_in), 32'(wd[w]));
    check("write_en", 32'(m_write_en), 32'(!req_rd[w]));
    check("read_en", 32'(m_read_en), 32'(req_rd[w]));
    if (drop) req[w] = 1'b0;
    tick();
    check("strobe_one_cycle", 32'({m_write_en, m_read_en}), 0);
    if (tmo) begin
      n = 1;
      while (req_done == '0 && n < TMO + 20) begin
        tick();
        n++;
      end
      check("timeout_latency", 32'(n), 32'(TMO + 1));
    end else begin
      repeat (dly) tick();
      m_busy = 1'b1;
      repeat (blen) tick();
      check("gnt_held", 32'(gnt), 32'(oh));
      m_busy     = 1'b0;
      m_done     = via_done;
      m_status   = st;
      m_data_out = dout;
      tick();
      m_done   = 1'b0;
      m_status = '0;
    end
    check("req_done", 32'(req_done), 32'(oh));
    check("req_err", 32'(req_err), tmo ? 32'd1 : 32'(st != 3'b000));
    if (!tmo && req_rd[w]) check("rd_data", 32'(rd_data), 32'(dout));
    last = w;
    req  = next_req;
    tick();
    check("done_one_cycle", 32'(req_done), 0);
    check("gnt_released", 32'(gnt), 0);
  endtask

  // Bus-level invariants checked every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_exclusive", 32'(m_write_en & m_read_en), 0);
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
    end
  end

  initial begin
    int lat;
    int n;
    logic [NREQ-1:0] r;

    reset = 1'b1; req = '0; req_rd = '0;
    m_busy = 1'b0; m_done = 1'b0; m_status = '0; m_data_out = '0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, '0, '0, '0);
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(req_done), 0);
    check("rst_err", 32'(req_err), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_m_cmd", 32'({m_chip_addr, m_reg_addr, m_data_in}), 0);
    check("rst_strobes", 32'({m_write_en, m_read_en}), 0);
    reset = 1'b0;
    tick();

    // Single write from requester 0: strobe in the cycle after the IDLE sample.
    set_cmd(0, 1'b0, 7'h72, 8'h41, 8'h40);
    req = 3'b001;
    check("no_early_strobe", 32'(m_write_en | m_read_en), 0);
    serve(0, 50, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000, lat);
    check("write_latency", 32'(lat), 1);

    // Read from requester 1.
    set_cmd(1, 1'b1, 7'h33, 8'h42, 8'h00);
    req = 3'b010;
    serve(1, 5, 3'b000, 8'h60, 1'b1, 1'b0, 1'b0, 3'b000, lat);

    // Start timeout: master never raises busy.
    set_cmd(2, 1'b0, 7'h11, 8'h22, 8'h33);
    req = 3'b100;
    serve(0, 0, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, lat);

    // NACK on requester 0, then requester 2 is served (busy fall, no done).
    set_cmd(0, 1'b1, 7'h50, 8'h10, 8'h00);
    set_cmd(2, 1'b0, 7'h51, 8'h11, 8'hA5);
    req = 3'b101;
    serve(0, 3, 3'b010, 8'h77, 1'b1, 1'b0, 1'b0, 3'b100, lat);
    serve(2, 2, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, lat);

    // Contention held from reset: order 0,1,2,0.
    reset = 1'b1;
    req   = 3'b111;
    repeat (2) tick();
    check("contend_rst_gnt", 32'(gnt), 0);
    reset = 1'b0;
    last  = NREQ - 1;
    for (int k = 0; k < 4; k++) begin
      check("contend_order", 32'(pick(req, last)), 32'(k % NREQ));
      serve(0, 2 + k, 3'b000, 8'(k), 1'b1, 1'b0, 1'b0, 3'b111, lat);
    end

    // Reset while waiting for done, then a fresh request completes.
    req = 3'b010;
    tick();
    n = 0;
    while (!(m_write_en || m_read_en) && n < 8) begin
      tick();
      n++;
    end
    check("pre_rst_strobe", 32'(m_write_en | m_read_en), 1);
    tick();
    m_busy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_done", 32'(req_done), 0);
    check("midrst_strobes", 32'({m_write_en, m_read_en}), 0);
    reset  = 1'b0;
    m_busy = 1'b0;
    last   = NREQ - 1;
    serve(1, 4, 3'b000, 8'h5A, 1'b1, 1'b0, 1'b0, 3'b000, lat);

    // Randomized traffic.
    r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    req = r;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 20)),
            ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            8'($urandom), 1'($urandom), 1'b0, 1'($urandom), r, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
